cdb_arbiter: RTL and testbench

Arbitrates completed results from all functional units onto the NUM_CDB common data bus ports. It sits between the FU outputs and the CDB, which feeds the RS wakeup, the map table and the regfile write ports. Each FU has a one-entry holding register that captures a losing result. The block drives per-FU stall signals back toward issue, so an FU with a held result accepts no new work.

---
 rtl/cdb_arbiter.sv | 146 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with per-FU one-entry holding registers (optional CDB_BR_PRIORITY_EN)
module cdb_arbiter #(
    parameter int NUM_FU  = 4,
    parameter int NUM_CDB = 2,
`ifdef CDB_BR_PRIORITY_EN
    // Branch FUs occupy the top NUM_FU_BR indices; NUM_CDB must exceed NUM_FU_BR
    parameter int NUM_FU_BR = 1,
`endif
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    localparam int ID_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 fu_done_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]      fu_done_tag,
    input  logic [NUM_FU-1:0][DATA_W-1:0]     fu_done_data,
    output logic [NUM_FU-1:0]                 fu_stall,
    output logic [NUM_CDB-1:0]                cdb_valid,
    output logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag,
    output logic [NUM_CDB-1:0][DATA_W-1:0]    cdb_data,
    output logic [NUM_CDB-1:0][ID_W-1:0]      cdb_fu_id
);

`ifdef CDB_BR_PRIORITY_EN
    // Branch FUs are granted up front and never join the rotating scan
    localparam logic [NUM_FU-1:0] BR_MASK = ~({NUM_FU{1'b1}} >> NUM_FU_BR);
    localparam logic [NUM_FU-1:0] SCAN_MASK = ~BR_MASK;
`else
    localparam logic [NUM_FU-1:0] SCAN_MASK = {NUM_FU{1'b1}};
`endif

    logic [NUM_FU-1:0]                hold_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]     hold_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]    hold_data;
    logic [ID_W-1:0]                  rr_ptr;

    logic [NUM_FU-1:0]                req;
    logic [NUM_FU-1:0][TAG_W-1:0]     src_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]    src_data;
    logic [NUM_FU-1:0]                gnt;
    logic [NUM_CDB-1:0]               sel_valid;
    logic [NUM_CDB-1:0][ID_W-1:0]     sel_id;
    logic [ID_W-1:0]                  next_ptr;
    int                               cnt;
    int                               idx;

`ifdef CDB_BR_PRIORITY_EN
    assign fu_stall = hold_valid & SCAN_MASK;
`else
    assign fu_stall = hold_valid;
`endif

    // A held result takes precedence; new input from that FU is ignored until it drains
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            req[i]      = hold_valid[i] | fu_done_valid[i];
            src_tag[i]  = hold_valid[i] ? hold_tag[i]  : fu_done_tag[i];
            src_data[i] = hold_valid[i] ? hold_data[i] : fu_done_data[i];
        end
    end

    // Port k goes to the k-th requester found scanning from rr_ptr
    always_comb begin
        gnt       = '0;
        sel_valid = '0;
        sel_id    = '0;
        next_ptr  = rr_ptr;
        cnt       = 0;
        idx       = 0;
`ifdef CDB_BR_PRIORITY_EN
        for (int i = NUM_FU - NUM_FU_BR; i < NUM_FU; i++) begin
            if (req[i] && cnt < NUM_CDB) begin
                gnt[i] = 1'b1;
                for (int p = 0; p < NUM_CDB; p++) begin
                    if (p == cnt) begin
                        sel_valid[p] = 1'b1;
                        sel_id[p]    = ID_W'(i);
                    end
                end
                cnt = cnt + 1;
            end
        end
`endif
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            for (int i = 0; i < NUM_FU; i++) begin
                if (i == idx && req[i] && SCAN_MASK[i] && cnt < NUM_CDB) begin
                    gnt[i] = 1'b1;
                    for (int p = 0; p < NUM_CDB; p++) begin
                        if (p == cnt) begin
                            sel_valid[p] = 1'b1;
                            sel_id[p]    = ID_W'(i);
                        end
                    end
                    next_ptr = (i == NUM_FU - 1) ? '0 : ID_W'(i + 1);
                    cnt = cnt + 1;
                end
            end
        end
    end

    // Control state: hold flags, rotation pointer and registered CDB broadcast
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            cdb_valid  <= '0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_fu_id  <= '0;
        end else if (flush) begin
            hold_valid <= '0;
            cdb_valid  <= '0;
        end else begin
            rr_ptr <= next_ptr;
            for (int i = 0; i < NUM_FU; i++) begin
                if (gnt[i])
                    hold_valid[i] <= 1'b0;
                else if (fu_done_valid[i] && SCAN_MASK[i])
                    hold_valid[i] <= 1'b1;
            end
            for (int p = 0; p < NUM_CDB; p++) begin
                cdb_valid[p] <= sel_valid[p];
                if (sel_valid[p]) begin
                    cdb_tag[p]   <= src_tag[sel_id[p]];
                    cdb_data[p]  <= src_data[sel_id[p]];
                    cdb_fu_id[p] <= sel_id[p];
                end
            end
        end
    end

    // Payload capture for losers; only meaningful once hold_valid is set
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (!gnt[i] && !hold_valid[i] && fu_done_valid[i]) begin
                hold_tag[i]  <= fu_done_tag[i];
                hold_data[i] <= fu_done_data[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter (NUM_FU=4, NUM_CDB=2)
module tb_cdb_arbiter;

    logic                  clock;
    logic                  reset;
    logic                  flush;
    logic [3:0]            fu_done_valid;
    logic [3:0][5:0]       fu_done_tag;
    logic [3:0][31:0]      fu_done_data;
    logic [3:0]            fu_stall;
    logic [1:0]            cdb_valid;
    logic [1:0][5:0]       cdb_tag;
    logic [1:0][31:0]      cdb_data;
    logic [1:0][1:0]       cdb_fu_id;

    int tests;
    int fails;

    cdb_arbiter #(.NUM_FU(4), .NUM_CDB(2), .TAG_W(6), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fu_done_valid(fu_done_valid), .fu_done_tag(fu_done_tag), .fu_done_data(fu_done_data),
        .fu_stall(fu_stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_fu_id(cdb_fu_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stimulus must never present a result to an FU that is stalled
    always @(negedge clock) begin
        if (reset && (fu_done_valid & fu_stall) != 4'b0000) begin
            fails++;
            $display("FAIL protocol: fu_done_valid=%b while fu_stall=%b", fu_done_valid, fu_stall);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input int base_tag);
        fu_done_valid = v;
        for (int i = 0; i < 4; i++) begin
            fu_done_tag[i]  = 6'(base_tag + i);
            fu_done_data[i] = 32'h1000 + 32'(base_tag + i);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive(4'b0000, 0);
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        drive(4'b1111, 40);
        tick();
        tick();
        tests++; if (cdb_valid !== 2'b00) begin fails++; $display("FAIL reset_cdb_valid: got %b want 00", cdb_valid); end
        tests++; if (fu_stall !== 4'b0000) begin fails++; $display("FAIL reset_fu_stall: got %b want 0000", fu_stall); end
        tests++; if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
        tests++; if (cdb_tag[0] !== 6'd0 || cdb_data[0] !== 32'd0 || cdb_fu_id[0] !== 2'd0) begin
            fails++; $display("FAIL reset_cdb_payload: tag %0d data %0h id %0d want 0", cdb_tag[0], cdb_data[0], cdb_fu_id[0]); end
        reset = 1'b1;
        drive(4'b0010, 0);
        fu_done_tag[1]  = 6'd5;
        fu_done_data[1] = 32'hAB;
        tick();
        drive(4'b0000, 0);
        tests++; if (cdb_valid !== 2'b01) begin fails++; $display("FAIL first_req_valid: got %b want 01", cdb_valid); end
        tests++; if (cdb_tag[0] !== 6'd5) begin fails++; $display("FAIL first_req_tag: got %0d want 5", cdb_tag[0]); end
        tests++; if (cdb_data[0] !== 32'hAB) begin fails++; $display("FAIL first_req_data: got %0h want ab", cdb_data[0]); end
        tests++; if (cdb_fu_id[0] !== 2'd1) begin fails++; $display("FAIL first_req_id: got %0d want 1", cdb_fu_id[0]); end
        tick();
        tests++; if (cdb_valid !== 2'b00) begin fails++; $display("FAIL first_req_drain: got %b want 00", cdb_valid); end
    endtask

    task automatic test_contention();
        apply_reset();
        drive(4'b1111, 1);
        tick();
        drive(4'b0000, 0);
        tests++; if (cdb_valid !== 2'b11) begin fails++; $display("FAIL cont1_valid: got %b want 11", cdb_valid); end
        tests++; if (cdb_tag[0] !== 6'd1 || cdb_tag[1] !== 6'd2) begin fails++; $display("FAIL cont1_tags: got %0d,%0d want 1,2", cdb_tag[0], cdb_tag[1]); end
        tests++; if (cdb_fu_id[0] !== 2'd0 || cdb_fu_id[1] !== 2'd1) begin fails++; $display("FAIL cont1_ids: got %0d,%0d want 0,1", cdb_fu_id[0], cdb_fu_id[1]); end
        tests++; if (fu_stall !== 4'b1100) begin fails++; $display("FAIL cont1_stall: got %b want 1100", fu_stall); end
        tick();
        tests++; if (cdb_valid !== 2'b11) begin fails++; $display("FAIL cont2_valid: got %b want 11", cdb_valid); end
        tests++; if (cdb_tag[0] !== 6'd3 || cdb_tag[1] !== 6'd4) begin fails++; $display("FAIL cont2_tags: got %0d,%0d want 3,4", cdb_tag[0], cdb_tag[1]); end
        tests++; if (cdb_data[0] !== 32'h1003 || cdb_data[1] !== 32'h1004) begin fails++; $display("FAIL cont2_data: got %0h,%0h want 1003,1004", cdb_data[0], cdb_data[1]); end
        tests++; if (fu_stall !== 4'b0000) begin fails++; $display("FAIL cont2_stall: got %b want 0000", fu_stall); end
        tests++; if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL cont2_rr_ptr: got %0d want 0", dut.rr_ptr); end
        tick();
        tests++; if (cdb_valid !== 2'b00) begin fails++; $display("FAIL cont_idle: got %b want 00", cdb_valid); end
    endtask

    task automatic test_wrap();
        drive(4'b0100, 7);
        tick();
        drive(4'b0000, 0);
        tests++; if (dut.rr_ptr !== 2'd3) begin fails++; $display("FAIL wrap_setup_ptr: got %0d want 3", dut.rr_ptr); end
        drive(4'b1001, 50);
        tick();
        drive(4'b0000, 0);
        tests++; if (cdb_valid !== 2'b11) begin fails++; $display("FAIL wrap_valid: got %b want 11", cdb_valid); end
        tests++; if (cdb_fu_id[0] !== 2'd3 || cdb_tag[0] !== 6'd53) begin fails++; $display("FAIL wrap_port0: got id %0d tag %0d want id 3 tag 53", cdb_fu_id[0], cdb_tag[0]); end
        tests++; if (cdb_fu_id[1] !== 2'd0 || cdb_tag[1] !== 6'd50) begin fails++; $display("FAIL wrap_port1: got id %0d tag %0d want id 0 tag 50", cdb_fu_id[1], cdb_tag[1]); end
        tests++; if (dut.rr_ptr !== 2'd1) begin fails++; $display("FAIL wrap_rr_ptr: got %0d want 1", dut.rr_ptr); end
        tick();
    endtask

    task automatic test_flush();
        drive(4'b0100, 7);
        tick();
        drive(4'b0111, 10);
        tick();
        tests++; if (cdb_tag[0] !== 6'd10 || cdb_tag[1] !== 6'd11) begin fails++; $display("FAIL flush_setup_tags: got %0d,%0d want 10,11", cdb_tag[0], cdb_tag[1]); end
        tests++; if (fu_stall !== 4'b0100) begin fails++; $display("FAIL flush_setup_stall: got %b want 0100", fu_stall); end
        tests++; if (dut.rr_ptr !== 2'd2) begin fails++; $display("FAIL flush_setup_ptr: got %0d want 2", dut.rr_ptr); end
        drive(4'b0010, 20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(4'b0000, 0);
        tests++; if (cdb_valid !== 2'b00) begin fails++; $display("FAIL flush_valid: got %b want 00", cdb_valid); end
        tests++; if (fu_stall !== 4'b0000) begin fails++; $display("FAIL flush_stall: got %b want 0000", fu_stall); end
        tests++; if (dut.rr_ptr !== 2'd2) begin fails++; $display("FAIL flush_rr_ptr: got %0d want 2", dut.rr_ptr); end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++; if (cdb_valid !== 2'b00) begin fails++; $display("FAIL flush_no_bcast: cycle %0d got %b want 00", c, cdb_valid); end
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b1111, 20);
        tick();
        drive(4'b0000, 0);
        tests++; if (cdb_fu_id[0] !== 2'd2 || cdb_fu_id[1] !== 2'd3) begin fails++; $display("FAIL mid_setup_ids: got %0d,%0d want 2,3", cdb_fu_id[0], cdb_fu_id[1]); end
        tests++; if (fu_stall !== 4'b0011) begin fails++; $display("FAIL mid_setup_stall: got %b want 0011", fu_stall); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests++; if (cdb_valid !== 2'b00) begin fails++; $display("FAIL mid_reset_valid: got %b want 00", cdb_valid); end
        tests++; if (fu_stall !== 4'b0000) begin fails++; $display("FAIL mid_reset_stall: got %b want 0000", fu_stall); end
        tests++; if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL mid_reset_ptr: got %0d want 0", dut.rr_ptr); end
        tick();
        tests++; if (cdb_valid !== 2'b00) begin fails++; $display("FAIL mid_reset_holds_gone: got %b want 00", cdb_valid); end
    endtask

    task automatic test_br_priority();
        apply_reset();
        drive(4'b1111, 30);
        tick();
        drive(4'b0000, 0);
`ifdef CDB_BR_PRIORITY_EN
        tests++; if (cdb_fu_id[0] !== 2'd3 || cdb_tag[0] !== 6'd33) begin fails++; $display("FAIL br_port0: got id %0d tag %0d want id 3 tag 33", cdb_fu_id[0], cdb_tag[0]); end
        tests++; if (cdb_fu_id[1] !== 2'd0 || cdb_tag[1] !== 6'd30) begin fails++; $display("FAIL br_port1: got id %0d tag %0d want id 0 tag 30", cdb_fu_id[1], cdb_tag[1]); end
        tests++; if (fu_stall !== 4'b0110) begin fails++; $display("FAIL br_stall: got %b want 0110", fu_stall); end
        tick();
        tests++; if (cdb_fu_id[0] !== 2'd1 || cdb_fu_id[1] !== 2'd2) begin fails++; $display("FAIL br_drain_ids: got %0d,%0d want 1,2", cdb_fu_id[0], cdb_fu_id[1]); end
        tests++; if (fu_stall !== 4'b0000) begin fails++; $display("FAIL br_drain_stall: got %b want 0000", fu_stall); end
`else
        tests++; if (cdb_fu_id[0] !== 2'd0 || cdb_tag[0] !== 6'd30) begin fails++; $display("FAIL rr_port0: got id %0d tag %0d want id 0 tag 30", cdb_fu_id[0], cdb_tag[0]); end
        tests++; if (cdb_fu_id[1] !== 2'd1 || cdb_tag[1] !== 6'd31) begin fails++; $display("FAIL rr_port1: got id %0d tag %0d want id 1 tag 31", cdb_fu_id[1], cdb_tag[1]); end
        tests++; if (fu_stall !== 4'b1100) begin fails++; $display("FAIL rr_stall: got %b want 1100", fu_stall); end
        tick();
        tests++; if (cdb_fu_id[0] !== 2'd2 || cdb_fu_id[1] !== 2'd3) begin fails++; $display("FAIL rr_drain_ids: got %0d,%0d want 2,3", cdb_fu_id[0], cdb_fu_id[1]); end
        tests++; if (cdb_data[0] !== 32'h1020 || cdb_data[1] !== 32'h1021) begin fails++; $display("FAIL rr_drain_data: got %0h,%0h want 1020,1021", cdb_data[0], cdb_data[1]); end
`endif
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        flush = 1'b0;
        drive(4'b0000, 0);
        test_reset();
        test_contention();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_br_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
